// File: rtl/count_sequencer_if.sv
// Command/configuration and status bundle between control logic and count_sequencer.
// The master drives commands and per-run configuration; the slave returns count and flags.
interface count_sequencer_if #(
  parameter int WIDTH      = 3,
  parameter int PRESCALE_W = 4
);
  logic                  start;
  logic                  stop;
  logic                  pause;
  logic                  mode_down;
  logic                  periodic;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tick;
  logic                  wrap;
  logic                  busy;
  logic                  done;

  modport master (
    output start, stop, pause, mode_down, periodic, limit, prescale,
    input  count, tick, wrap, busy, done
  );

  modport slave (
    input  start, stop, pause, mode_down, periodic, limit, prescale,
    output count, tick, wrap, busy, done
  );
endinterface

// File: rtl/count_sequencer.sv
// Prescaled up/down run sequencer: start/stop/pause commands, per-run latched
// configuration, one-shot or periodic runs, registered count/tick/wrap outputs.
module count_sequencer #(
  parameter int WIDTH      = 3,
  parameter int PRESCALE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  count_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PSC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                state_q, state_nxt;
  logic [WIDTH-1:0]      count_q, count_nxt;
  logic [WIDTH-1:0]      limit_q, limit_nxt;
  logic [PRESCALE_W-1:0] psc_q, psc_nxt;
  logic [PRESCALE_W-1:0] ps_q, ps_nxt;
  logic                  down_q, down_nxt;
  logic                  per_q, per_nxt;
  logic                  tick_q, tick_nxt;
  logic                  wrap_q, wrap_nxt;
  logic                  advance;
  logic [WIDTH-1:0]      end_val;
  logic [WIDTH-1:0]      start_val;

  function automatic logic [WIDTH-1:0] step_count(input logic [WIDTH-1:0] c,
                                                  input logic down);
    return down ? (c - CNT_ONE) : (c + CNT_ONE);
  endfunction

  assign end_val   = down_q ? '0 : limit_q;
  assign start_val = down_q ? limit_q : '0;

  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    psc_nxt   = psc_q;
    limit_nxt = limit_q;
    ps_nxt    = ps_q;
    down_nxt  = down_q;
    per_nxt   = per_q;
    tick_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    advance   = 1'b0;

    if (bus.stop) begin
      state_nxt = IDLE;
      count_nxt = '0;
      psc_nxt   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            limit_nxt = bus.limit;
            ps_nxt    = bus.prescale;
            down_nxt  = bus.mode_down;
            per_nxt   = bus.periodic;
            count_nxt = bus.mode_down ? bus.limit : '0;
            psc_nxt   = '0;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (bus.pause) state_nxt = PAUSE;
          else           advance   = 1'b1;
        end
        // Leaving PAUSE advances on the same edge, so only edges sampled with
        // pause high are lost and the run is shifted by exactly that amount.
        PAUSE: begin
          if (!bus.pause) begin
            state_nxt = RUN;
            advance   = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (advance) begin
      if (psc_q == ps_q) begin
        psc_nxt  = '0;
        tick_nxt = 1'b1;
        if (count_q == end_val) begin
          wrap_nxt = 1'b1;
          if (per_q) count_nxt = start_val;
          else       state_nxt = DONE;
        end else begin
          count_nxt = step_count(count_q, down_q);
        end
      end else begin
        psc_nxt = psc_q + PSC_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      psc_q   <= '0;
      limit_q <= '0;
      ps_q    <= '0;
      down_q  <= 1'b0;
      per_q   <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      count_q <= count_nxt;
      psc_q   <= psc_nxt;
      limit_q <= limit_nxt;
      ps_q    <= ps_nxt;
      down_q  <= down_nxt;
      per_q   <= per_nxt;
      tick_q  <= tick_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick_q;
  assign bus.wrap  = wrap_q;
  assign bus.busy  = (state_q == RUN) || (state_q == PAUSE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer; observed word is {count, tick, wrap, busy, done}.
module tb_count_sequencer;

  localparam int WIDTH      = 3;
  localparam int PRESCALE_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  count_sequencer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  count_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [6:0] obs();
    return {bus.count, bus.tick, bus.wrap, bus.busy, bus.done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.pause     = 1'b0;
    bus.mode_down = 1'b0;
    bus.periodic  = 1'b0;
    bus.limit     = '0;
    bus.prescale  = '0;
    #12;
    got = obs();
    n_cmp++;
    if (got !== 7'b000_0_0_0_0) begin
      n_bad++;
      $display("FAIL reset_state: got %b, want %b", got, 7'b0);
    end
    rst = 1'b0;
    step();
    got = obs();
    n_cmp++;
    if (got !== 7'b000_0_0_0_0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b, want %b", got, 7'b0);
    end
  endtask

  task automatic test_oneshot_up();
    logic [6:0] got, exp;
    bus.limit = 3'd5; bus.prescale = 4'd0; bus.mode_down = 1'b0; bus.periodic = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    // live configuration changes must not disturb the latched run
    bus.limit = 3'd2; bus.mode_down = 1'b1;
    got = obs(); exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL oneshot_start: got %b, want %b", got, exp);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      got = obs(); exp = {3'(i), 1'b1, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL oneshot_step%0d: got %b, want %b", i, got, exp);
      end
    end
    step();
    got = obs(); exp = {3'd5, 1'b1, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL oneshot_terminal: got %b, want %b", got, exp);
    end
    step();
    got = obs(); exp = {3'd5, 1'b0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL oneshot_done_hold: got %b, want %b", got, exp);
    end
    bus.mode_down = 1'b0;
  endtask

  task automatic test_periodic_down();
    logic [6:0] got, exp;
    int cnt_tab [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    int cur;
    logic tk, wr;
    bus.limit = 3'd3; bus.prescale = 4'd2; bus.mode_down = 1'b1; bus.periodic = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    got = obs(); exp = {3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL down_start: got %b, want %b", got, exp);
    end
    cur = 3;
    for (int c = 1; c <= 24; c++) begin
      step();
      tk = (c % 3 == 0);
      wr = tk && ((c / 3) % 4 == 0);
      if (tk) cur = cnt_tab[c/3 - 1];
      got = obs(); exp = {3'(cur), tk, wr, 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL down_periodic_c%0d: got %b, want %b", c, got, exp);
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    got = obs(); exp = 7'b0;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL stop_in_run: got %b, want %b", got, exp);
    end
    bus.mode_down = 1'b0;
  endtask

  task automatic test_pause();
    logic [6:0] got, exp;
    int pre_tab  [6]  = '{0, 1, 1, 2, 2, 3};
    int post_tab [10] = '{3, 4, 4, 5, 5, 6, 6, 7, 7, 0};
    bus.limit = 3'd7; bus.prescale = 4'd1; bus.mode_down = 1'b0; bus.periodic = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    got = obs(); exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL pause_start: got %b, want %b", got, exp);
    end
    for (int e = 1; e <= 6; e++) begin
      step();
      got = obs(); exp = {3'(pre_tab[e-1]), (e % 2 == 0), 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL pause_pre_e%0d: got %b, want %b", e, got, exp);
      end
    end
    bus.pause = 1'b1;
    for (int e = 7; e <= 16; e++) begin
      step();
      got = obs(); exp = {3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL pause_frozen_e%0d: got %b, want %b", e, got, exp);
      end
    end
    bus.pause = 1'b0;
    for (int e = 17; e <= 27; e++) begin
      step();
      if (e == 27) exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      else         exp = {3'(post_tab[e-17]), (e % 2 == 0), (e == 26), 1'b1, 1'b0};
      got = obs();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL pause_post_e%0d: got %b, want %b", e, got, exp);
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
  endtask

  task automatic test_start_ignored_stop_pause();
    logic [6:0] got, exp;
    bus.limit = 3'd7; bus.prescale = 4'd3; bus.mode_down = 1'b0; bus.periodic = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.limit = 3'd2; bus.mode_down = 1'b1;
    step();
    bus.start = 1'b0;
    got = obs(); exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL start_in_run_ignored: got %b, want %b", got, exp);
    end
    step();
    step();
    got = obs(); exp = {3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL run_continues: got %b, want %b", got, exp);
    end
    bus.pause = 1'b1;
    step();
    got = obs(); exp = {3'd1, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL paused_busy: got %b, want %b", got, exp);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0; bus.pause = 1'b0; bus.mode_down = 1'b0;
    got = obs(); exp = 7'b0;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL stop_in_pause: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_limit_zero_stop_start();
    logic [6:0] got, exp;
    bus.limit = 3'd0; bus.prescale = 4'd0; bus.mode_down = 1'b0; bus.periodic = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    got = obs(); exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL limit0_start: got %b, want %b", got, exp);
    end
    step();
    got = obs(); exp = {3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL limit0_terminal: got %b, want %b", got, exp);
    end
    bus.stop = 1'b1; bus.start = 1'b1;
    step();
    bus.stop = 1'b0; bus.start = 1'b0;
    got = obs(); exp = 7'b0;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL stop_start_in_done: got %b, want %b", got, exp);
    end
    step();
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL idle_stays: got %b, want %b", got, exp);
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] got, exp;
    bus.limit = 3'd5; bus.prescale = 4'd0; bus.mode_down = 1'b0; bus.periodic = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    got = obs(); exp = {3'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL pre_reset_run: got %b, want %b", got, exp);
    end
    #3 rst = 1'b1;
    #1;
    got = obs(); exp = 7'b0;
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL async_reset_immediate: got %b, want %b", got, exp);
    end
    step();
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_held: got %b, want %b", got, exp);
    end
    #3 rst = 1'b0;
    step();
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL after_reset_idle: got %b, want %b", got, exp);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    got = obs(); exp = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL restart_start: got %b, want %b", got, exp);
    end
    step();
    got = obs(); exp = {3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL restart_step: got %b, want %b", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_oneshot_up();
    test_periodic_down();
    test_pause();
    test_start_ignored_stop_pause();
    test_limit_zero_stop_start();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
